// File: rtl/grasshopper_key_schedule.sv
// Kuznyechik (GOST R 34.12-2015) key expansion: one Feistel round at a time,
// byte-serial linear transform, streams K1..K10 tagged with index 0..9.
module grasshopper_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_i,
  input  logic         start_i,
  output logic         busy,
  output logic         round_key_valid_o,
  output logic [3:0]   round_key_num_o,
  output logic [127:0] round_key_o,
  output logic         done_o
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned NRND  = 32;

  typedef enum logic [2:0] {IDLE, EMIT_A, EMIT_B, SUB, LIN, DONE} state_t;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Coefficient for byte t15 first, down to t0
  localparam logic [7:0] LC [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] l_fn(input logic [BLK_W-1:0] t);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(LC[k], t[8*(15-k) +: 8]);
    return acc;
  endfunction

  function automatic logic [BLK_W-1:0] r_fn(input logic [BLK_W-1:0] t);
    return {l_fn(t), t[BLK_W-1:8]};
  endfunction

  function automatic logic [BLK_W-1:0] s_fn(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = PI[x[8*k +: 8]];
    return s;
  endfunction

  // Round constant C_i = L(i), evaluated at elaboration
  function automatic logic [BLK_W-1:0] calc_c(input int i);
    logic [BLK_W-1:0] t;
    t = BLK_W'(i);
    for (int k = 0; k < 16; k++) t = r_fn(t);
    return t;
  endfunction

  logic [BLK_W-1:0] w_rom [NRND];

  for (genvar g = 0; g < NRND; g++) begin : g_rom
    localparam logic [BLK_W-1:0] C = calc_c(g + 1);
    assign w_rom[g] = C;
  end

  state_t           r_state, w_state;
  logic [BLK_W-1:0] r_a1, r_a0, r_t;
  logic [BLK_W-1:0] w_a1, w_a0, w_t;
  logic [3:0]       r_cnt, w_cnt;
  logic [5:0]       r_rnd, w_rnd;
  logic             w_valid, w_done, w_busy;
  logic [3:0]       w_num;
  logic [BLK_W-1:0] w_key;
  logic [BLK_W-1:0] w_c;

  assign w_c = w_rom[r_rnd[4:0]];

  // Next-state, datapath and output decode
  always_comb begin
    w_state = r_state;
    w_a1    = r_a1;
    w_a0    = r_a0;
    w_t     = r_t;
    w_cnt   = r_cnt;
    w_rnd   = r_rnd;
    w_valid = 1'b0;
    w_done  = 1'b0;
    w_num   = round_key_num_o;
    w_key   = round_key_o;
    w_busy  = (r_state != IDLE) && (r_state != DONE);
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_a1    = key_i[255:128];
          w_a0    = key_i[127:0];
          w_rnd   = '0;
          w_cnt   = '0;
          w_state = EMIT_A;
        end else begin
          w_state = IDLE;
        end
      end
      EMIT_A: begin
        w_valid = 1'b1;
        w_num   = r_rnd[5:2];
        w_key   = r_a1;
        w_state = EMIT_B;
      end
      EMIT_B: begin
        w_valid = 1'b1;
        w_num   = r_rnd[5:2] + 4'd1;
        w_key   = r_a0;
        if (r_rnd == 6'd32) begin
          w_done  = 1'b1;
          w_state = DONE;
        end else begin
          w_state = SUB;
        end
      end
      SUB: begin
        w_t     = s_fn(r_a1 ^ w_c);
        w_cnt   = '0;
        w_state = LIN;
      end
      LIN: begin
        w_t   = r_fn(r_t);
        w_cnt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_a1  = w_t ^ r_a0;
          w_a0  = r_a1;
          w_rnd = r_rnd + 6'd1;
          w_state = (w_rnd[2:0] == 3'd0) ? EMIT_A : SUB;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= IDLE;
      r_a1              <= '0;
      r_a0              <= '0;
      r_t               <= '0;
      r_cnt             <= '0;
      r_rnd             <= '0;
      busy              <= 1'b0;
      round_key_valid_o <= 1'b0;
      round_key_num_o   <= '0;
      round_key_o       <= '0;
      done_o            <= 1'b0;
    end else begin
      r_state           <= w_state;
      r_a1              <= w_a1;
      r_a0              <= w_a0;
      r_t               <= w_t;
      r_cnt             <= w_cnt;
      r_rnd             <= w_rnd;
      busy              <= w_busy;
      round_key_valid_o <= w_valid;
      round_key_num_o   <= w_num;
      round_key_o       <= w_key;
      done_o            <= w_done;
    end
  end

endmodule

// File: tb/tb_grasshopper_key_schedule.sv
// Bench for grasshopper_key_schedule: literal standard vector table, hand
// sequences for busy/back-to-back/reset corners, random keys vs a model.
module tb_grasshopper_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] key_i = '0;
  logic         start_i = 1'b0;
  logic         busy;
  logic         round_key_valid_o;
  logic [3:0]   round_key_num_o;
  logic [127:0] round_key_o;
  logic         done_o;

  grasshopper_key_schedule dut (
    .clk              (clk),
    .rst              (rst),
    .key_i            (key_i),
    .start_i          (start_i),
    .busy             (busy),
    .round_key_valid_o(round_key_valid_o),
    .round_key_num_o  (round_key_num_o),
    .round_key_o      (round_key_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         valid;
    logic [3:0]   num;
    logic [127:0] key;
    logic         done;
  } strobe_t;

  strobe_t q[$];

  always @(negedge clk)
    if (round_key_valid_o || done_o)
      q.push_back('{cyc, round_key_valid_o, round_key_num_o, round_key_o, done_o});

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic ok, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- reference model ----------------
  localparam logic [7:0] PI_T [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Coefficient of byte t_b, indexed by b (t0 = least significant byte)
  localparam int COEF [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};

  // Carry-less product then polynomial reduction by 0x1C3
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int bb = 14; bb >= 8; bb--) if (p[bb]) p = p ^ (16'h01C3 << (bb - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] m_L(input logic [127:0] x);
    logic [7:0] acc;
    for (int r = 0; r < 16; r++) begin
      acc = '0;
      for (int b = 0; b < 16; b++) acc = acc ^ m_mul(8'(COEF[b]), x[8*b +: 8]);
      x = {acc, x[127:8]};
    end
    return x;
  endfunction

  function automatic logic [127:0] m_S(input logic [127:0] x);
    logic [127:0] y;
    for (int b = 0; b < 16; b++) y[8*b +: 8] = PI_T[x[8*b +: 8]];
    return y;
  endfunction

  logic [127:0] m_rk [10];

  task automatic model(input logic [255:0] k);
    logic [127:0] a1, a0, t;
    a1 = k[255:128];
    a0 = k[127:0];
    m_rk[0] = a1;
    m_rk[1] = a0;
    for (int i = 1; i <= 32; i++) begin
      t  = m_L(m_S(a1 ^ m_L(128'(i)))) ^ a0;
      a0 = a1;
      a1 = t;
      if (i % 8 == 0) begin
        m_rk[i/4]   = a1;
        m_rk[i/4+1] = a0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  logic [127:0] got_key [10];
  int           got_cyc [10];

  task automatic wait_until(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Returns the number of the edge that accepted the start
  task automatic do_start(input logic [255:0] k, output int s);
    @(negedge clk);
    start_i = 1'b1;
    key_i   = k;
    @(negedge clk);
    start_i = 1'b0;
    s = cyc;
  endtask

  task automatic check_strobes(input string name, input int s, input logic [255:0] k);
    int ec;
    model(k);
    chk({name, "_count"}, q.size() == 10, $sformatf("got %0d strobes, want 10", q.size()));
    for (int n = 0; n < 10; n++) begin
      ec = s + 138 * (n / 2) + 1 + (n % 2);
      got_key[n] = 'x;
      got_cyc[n] = -1;
      if (n < q.size()) begin
        got_key[n] = q[n].key;
        got_cyc[n] = q[n].cyc;
        chk($sformatf("%s_k%0d", name, n),
            q[n].valid === 1'b1 && q[n].cyc == ec && q[n].num == 4'(n) &&
            q[n].key === m_rk[n] && q[n].done === (n == 9),
            $sformatf("got cyc=%0d v=%b num=%0d key=%h done=%b, want cyc=%0d v=1 num=%0d key=%h done=%b",
                      q[n].cyc, q[n].valid, q[n].num, q[n].key, q[n].done, ec, n, m_rk[n], n == 9));
      end else begin
        chk($sformatf("%s_k%0d", name, n), 1'b0, $sformatf("missing strobe, want cyc=%0d", ec));
      end
    end
    q.delete();
  endtask

  typedef struct {
    int           num;
    int           rel_cyc;
    logic [127:0] val;
  } vec_t;

  localparam logic [255:0] STD_KEY =
    256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [255:0] BAD_KEY = {8{32'hA5A55A5A}};

  // ---------------- test ----------------
  initial begin
    vec_t         tbl [5];
    int           s, s2;
    logic [255:0] rk;

    tbl[0] = '{0,   1, 128'h8899aabbccddeeff0011223344556677};
    tbl[1] = '{1,   2, 128'hfedcba98765432100123456789abcdef};
    tbl[2] = '{2, 139, 128'hdb31485315694343228d6aef8cc78c44};
    tbl[3] = '{3, 140, 128'h3d4553d8e9cfec6815ebadc40a9ffd04};
    tbl[4] = '{9, 554, 128'h72e9dd7416bcf45b755dbaa88e4a4043};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        busy === 1'b0 && round_key_valid_o === 1'b0 && round_key_num_o === 4'd0 &&
        round_key_o === 128'd0 && done_o === 1'b0,
        $sformatf("got busy=%b v=%b num=%0d key=%h done=%b, want all zero",
                  busy, round_key_valid_o, round_key_num_o, round_key_o, done_o));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // all-zero key, with round constant and first-round probe
    do_start('0, s);
    chk("rom_c1", dut.w_rom[0] === 128'h6ea276726c487ab85d27bd10dd849401,
        $sformatf("got %h, want 6ea276726c487ab85d27bd10dd849401", dut.w_rom[0]));
    wait_until(s + 19);
    rk = {m_L(m_S(m_L(128'd1))), 128'd0};
    chk("round1_a1", dut.r_a1 === rk[255:128], $sformatf("got %h, want %h", dut.r_a1, rk[255:128]));
    wait_until(s + 555);
    check_strobes("zero", s, '0);
    chk("zero_k1k2", got_key[0] === 128'd0 && got_key[1] === 128'd0,
        $sformatf("got %h %h, want zero", got_key[0], got_key[1]));

    // standard vector with ignored starts at 100 and 554, restart at 555
    do_start(STD_KEY, s);
    wait_until(s + 99);
    start_i = 1'b1; key_i = BAD_KEY;
    wait_until(s + 100);
    start_i = 1'b0;
    wait_until(s + 553);
    start_i = 1'b1;
    wait_until(s + 554);
    chk("busy_at_554", busy === 1'b1, $sformatf("got %b, want 1", busy));
    key_i = STD_KEY;
    wait_until(s + 555);
    start_i = 1'b0;
    chk("busy_at_555", busy === 1'b0, $sformatf("got %b, want 0", busy));
    check_strobes("std", s, STD_KEY);
    for (int i = 0; i < 5; i++)
      chk($sformatf("std_table_k%0d", tbl[i].num),
          got_key[tbl[i].num] === tbl[i].val && got_cyc[tbl[i].num] == s + tbl[i].rel_cyc,
          $sformatf("got %h @%0d, want %h @%0d", got_key[tbl[i].num], got_cyc[tbl[i].num] - s,
                    tbl[i].val, tbl[i].rel_cyc));

    // back-to-back run accepted at edge s+555
    s2 = s + 555;
    wait_until(s2 + 1);
    chk("b2b_busy", busy === 1'b1, $sformatf("got %b, want 1", busy));
    wait_until(s2 + 555);
    check_strobes("b2b", s2, STD_KEY);

    // reset in the middle of an expansion
    do_start(STD_KEY, s);
    wait_until(s + 200);
    rst = 1'b0;
    q.delete();
    for (int c = 200; c <= 204; c++) begin
      if (c > 200) wait_until(s + c);
      #1;
      chk($sformatf("in_reset_%0d", c),
          busy === 1'b0 && round_key_valid_o === 1'b0 && round_key_num_o === 4'd0 &&
          round_key_o === 128'd0 && done_o === 1'b0,
          $sformatf("got busy=%b v=%b num=%0d key=%h done=%b, want all zero",
                    busy, round_key_valid_o, round_key_num_o, round_key_o, done_o));
    end
    wait_until(s + 205);
    rst = 1'b1;
    wait_until(s + 209);
    chk("no_strobe_in_reset", q.size() == 0, $sformatf("got %0d strobes, want 0", q.size()));
    start_i = 1'b1; key_i = STD_KEY;
    wait_until(s + 210);
    start_i = 1'b0;
    wait_until(s + 210 + 555);
    check_strobes("after_rst", s + 210, STD_KEY);

    // random keys against the model
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
      do_start(rk, s);
      wait_until(s + 555);
      check_strobes($sformatf("rand%0d", r), s, rk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
